// File: rtl/rol_seq_pkg.sv
// Shared definitions for the sequential rotate-left unit.
//   ROL_WIDTH   : default operand/result width (power of two, >= 2)
//   ROL_SHAMT_W : number of low Rc bits forming the rotate amount
//   rol_state_t : controller states
//   k_width()   : width of the stride index k for a given amount width
package rol_seq_pkg;

  localparam int unsigned ROL_WIDTH   = 32;
  localparam int unsigned ROL_SHAMT_W = $clog2(ROL_WIDTH);

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } rol_state_t;

  // k selects one of shamt_w strides; keep it at least one bit wide so that
  // a WIDTH=2 build (a single stride) still has a legal index register.
  function automatic int unsigned k_width(input int unsigned shamt_w);
    return (shamt_w > 1) ? $clog2(shamt_w) : 1;
  endfunction

endpackage

// File: rtl/rol_seq_if.sv
// Start/done handshake bundle between the control unit and the rotate unit.
//   master : requester (drives start/Rb/Rc, observes busy/done/Ra)
//   slave  : rotate unit (observes start/Rb/Rc, drives busy/done/Ra)
interface rol_seq_if
  import rol_seq_pkg::*;
#(
  parameter int unsigned WIDTH = ROL_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] Rb;
  logic [WIDTH-1:0] Rc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Ra;

  modport master (
    output start, Rb, Rc,
    input  busy, done, Ra
  );

  modport slave (
    input  start, Rb, Rc,
    output busy, done, Ra
  );

endinterface

// File: rtl/rol_pow2.sv
// Combinational rotate-left of a WIDTH-bit operand by 2**k_i.
//   data_i : operand
//   k_i    : stride exponent, valid range 0 .. SHAMT_W-1
//   data_o : data_i rotated left by 2**k_i (data_i unchanged if k_i out of range)
module rol_pow2
  import rol_seq_pkg::*;
#(
  parameter int unsigned WIDTH = ROL_WIDTH
) (
  input  logic [WIDTH-1:0]                   data_i,
  input  logic [k_width($clog2(WIDTH))-1:0]  k_i,
  output logic [WIDTH-1:0]                   data_o
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned KW      = k_width(SHAMT_W);

  logic [WIDTH-1:0] stride [SHAMT_W];

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stride
    localparam int unsigned S = 1 << i;
    assign stride[i] = {data_i[WIDTH-1-S:0], data_i[WIDTH-1 -: S]};
  end

  always_comb begin
    data_o = data_i;
    for (int unsigned i = 0; i < SHAMT_W; i++) begin
      if (k_i == KW'(i)) begin
        data_o = stride[i];
      end
    end
  end

endmodule

// File: rtl/rol_seq.sv
// Multi-cycle rotate-left unit: Ra = Rb rotated left by (Rc mod WIDTH).
// One amount bit is consumed per cycle using power-of-two strides; the
// operation finishes as soon as the remaining amount is zero.
//   clk   : rising-edge clock
//   clr_n : asynchronous active-low reset
//   bus   : start/Rb/Rc request, busy/done/Ra response (slave side)
module rol_seq
  import rol_seq_pkg::*;
#(
  parameter int unsigned WIDTH = ROL_WIDTH
) (
  input logic       clk,
  input logic       clr_n,
  rol_seq_if.slave  bus
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned KW      = k_width(SHAMT_W);

  rol_state_t         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   acc_rot;

  // Rc bits above the amount field are architecturally ignored.
  logic unused_rc_hi;
  assign unused_rc_hi = ^bus.Rc[WIDTH-1:SHAMT_W];

  rol_pow2 #(
    .WIDTH (WIDTH)
  ) u_pow2 (
    .data_i (acc_q),
    .k_i    (k_q),
    .data_o (acc_rot)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    k_d     = k_q;
    ra_d    = ra_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = bus.Rb;
          amt_d   = bus.Rc[SHAMT_W-1:0];
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (amt_q != '0) begin
          // Bit k of the original amount selects a 2**k stride.
          if (amt_q[0]) begin
            acc_d = acc_rot;
          end
          amt_d = amt_q >> 1;
          k_d   = k_q + KW'(1);
        end else begin
          ra_d    = acc_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      k_q     <= '0;
      ra_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      k_q     <= k_d;
      ra_q    <= ra_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Ra   = ra_q;

endmodule

// File: tb/tb_rol_seq.sv
// Directed self-checking bench for rol_seq (WIDTH=32).
module tb_rol_seq;

  logic clk;
  logic clr_n;
  int   tests;
  int   fails;

  rol_seq_if #(.WIDTH(32)) bus ();

  rol_seq #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one operation and observe it. lat = edges from the start-sampling
  // edge to done high (-1 on timeout); busy_cyc = observed cycles with busy
  // before done; overlap = cycles with busy and done both high.
  task automatic do_op(input logic [31:0] rb, input logic [31:0] rc, output int lat,
                       output logic [31:0] ra, output int busy_cyc, output int overlap);
    @(negedge clk);
    bus.start = 1'b1;
    bus.Rb    = rb;
    bus.Rc    = rc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.Rb    = '0;
    bus.Rc    = '0;
    lat      = -1;
    ra       = bus.Ra;
    busy_cyc = bus.busy ? 1 : 0;
    overlap  = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.busy && bus.done) overlap++;
      if (bus.done) begin
        lat = n;
        ra  = bus.Ra;
        break;
      end
      if (bus.busy) busy_cyc++;
    end
  endtask

  task automatic test_reset;
    clr_n     = 1'b0;
    bus.start = 1'b1;
    bus.Rb    = 32'hFFFF_FFFF;
    bus.Rc    = 32'h1;
    repeat (3) @(negedge clk);
    tests++; if (bus.Ra !== 32'h0) begin fails++; $display("FAIL reset_ra: got %h want 0", bus.Ra); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
    bus.start = 1'b0;
    clr_n     = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL post_reset_done: got %b want 0", bus.done); end
  endtask

  task automatic test_rotate_one;
    int lat, bc, ov;
    logic [31:0] ra;
    do_op(32'h8000_0001, 32'd1, lat, ra, bc, ov);
    tests++; if (lat != 2) begin fails++; $display("FAIL rol1_latency: got %0d want 2", lat); end
    tests++; if (ra !== 32'h0000_0003) begin fails++; $display("FAIL rol1_ra: got %h want 00000003", ra); end
    tests++; if (bc != 2) begin fails++; $display("FAIL rol1_busy_cycles: got %0d want 2", bc); end
    tests++; if (ov != 0) begin fails++; $display("FAIL rol1_busy_done_overlap: got %0d want 0", ov); end
    @(negedge clk);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rol1_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_zero_amount;
    int lat, bc, ov;
    logic [31:0] ra;
    do_op(32'hDEAD_BEEF, 32'd0, lat, ra, bc, ov);
    tests++; if (lat != 1) begin fails++; $display("FAIL rc0_latency: got %0d want 1", lat); end
    tests++; if (ra !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rc0_ra: got %h want deadbeef", ra); end
    tests++; if (bc != 1) begin fails++; $display("FAIL rc0_busy_cycles: got %0d want 1", bc); end
    do_op(32'hDEAD_BEEF, 32'd32, lat, ra, bc, ov);
    tests++; if (lat != 1) begin fails++; $display("FAIL rc32_latency: got %0d want 1", lat); end
    tests++; if (ra !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rc32_ra: got %h want deadbeef", ra); end
  endtask

  task automatic test_amounts;
    logic [31:0] vec_rb  [5] = '{32'h1234_5678, 32'h0000_0001, 32'h1234_5678, 32'h8000_0000,
                                 32'hA5A5_A5A5};
    logic [31:0] vec_rc  [5] = '{32'd36, 32'd31, 32'd16, 32'd3, 32'd5};
    logic [31:0] vec_ra  [5] = '{32'h2345_6781, 32'h8000_0000, 32'h5678_1234, 32'h0000_0004,
                                 32'hB4B4_B4B4};
    int          vec_lat [5] = '{4, 6, 6, 3, 4};
    int lat, bc, ov;
    logic [31:0] ra;
    for (int i = 0; i < 5; i++) begin
      do_op(vec_rb[i], vec_rc[i], lat, ra, bc, ov);
      tests++;
      if (lat != vec_lat[i]) begin
        fails++; $display("FAIL amt%0d_latency: got %0d want %0d", i, lat, vec_lat[i]);
      end
      tests++;
      if (ra !== vec_ra[i]) begin
        fails++; $display("FAIL amt%0d_ra: got %h want %h", i, ra, vec_ra[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] ra;
    @(negedge clk);
    bus.start = 1'b1; bus.Rb = 32'h0000_0001; bus.Rc = 32'd31;
    @(negedge clk);                                   // edge 0 sampled
    bus.start = 1'b0;
    @(negedge clk);                                   // after edge 1
    bus.start = 1'b1; bus.Rb = 32'hFFFF_FFFF; bus.Rc = 32'd1;
    @(negedge clk);                                   // edge 2 must ignore it
    bus.start = 1'b0; bus.Rb = '0; bus.Rc = '0;
    lat = -1;
    ra  = bus.Ra;
    for (int n = 3; n <= 20; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        ra  = bus.Ra;
        bus.start = 1'b1; bus.Rb = 32'hFFFF_FFFF; bus.Rc = 32'd1;
        break;
      end
    end
    tests++; if (lat != 6) begin fails++; $display("FAIL ignore_latency: got %0d want 6", lat); end
    tests++; if (ra !== 32'h8000_0000) begin fails++; $display("FAIL ignore_ra: got %h want 80000000", ra); end
    @(negedge clk);                                   // start taken in done cycle
    bus.start = 1'b0; bus.Rb = '0; bus.Rc = '0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b want 1", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL b2b_single_done: got %b want 0", bus.done); end
    @(negedge clk);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL b2b_early_done: got %b want 0", bus.done); end
    @(negedge clk);
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL b2b_done: got %b want 1", bus.done); end
    tests++; if (bus.Ra !== 32'hFFFF_FFFF) begin fails++; $display("FAIL b2b_ra: got %h want ffffffff", bus.Ra); end
  endtask

  task automatic test_mid_reset;
    int lat, bc, ov, seen;
    logic [31:0] ra;
    @(negedge clk);
    bus.start = 1'b1; bus.Rb = 32'h0000_0001; bus.Rc = 32'd31;
    @(negedge clk);
    bus.start = 1'b0; bus.Rb = '0; bus.Rc = '0;
    repeat (2) @(negedge clk);                        // third RUN cycle
    #2 clr_n = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    tests++; if (bus.Ra !== 32'h0) begin fails++; $display("FAIL midrst_ra: got %h want 0", bus.Ra); end
    @(negedge clk);
    clr_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL midrst_no_done: got %0d active cycles want 0", seen); end
    do_op(32'h0000_000F, 32'd8, lat, ra, bc, ov);
    tests++; if (lat != 5) begin fails++; $display("FAIL restart_latency: got %0d want 5", lat); end
    tests++; if (ra !== 32'h0000_0F00) begin fails++; $display("FAIL restart_ra: got %h want 00000f00", ra); end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    clr_n     = 1'b0;
    bus.start = 1'b0;
    bus.Rb    = '0;
    bus.Rc    = '0;
    test_reset();
    test_rotate_one();
    test_zero_amount();
    test_amounts();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
